// File: rtl/uart_alu_interface.sv
// Sequencer between UART RX, a combinational ALU and UART TX: gathers A, B and
// opcode bytes, latches the ALU result, launches one TX frame and waits for it.
module uart_alu_interface #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned NB_TIMEOUT     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_rx_drop
);

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // A zero cycle count disables the timeout; the timer then never leaves 0.
  localparam bit                    TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [NB_TIMEOUT-1:0] TIMER_LAST =
    TIMEOUT_EN ? NB_TIMEOUT'(TIMEOUT_CYCLES - 1) : '0;

  state_t              r_state;
  logic [NB_TIMEOUT-1:0] r_timer;
  logic [NB_DATA-1:0]  r_alu_a;
  logic [NB_DATA-1:0]  r_alu_b;
  logic [NB_OP-1:0]    r_alu_op;
  logic [NB_DATA-1:0]  r_tx_data;
  logic                r_tx_start;
  logic                r_busy;
  logic                r_timeout;
  logic                r_rx_drop;
  logic                w_expired;

  assign w_expired = TIMEOUT_EN && (r_timer == TIMER_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_WAIT_A;
      r_timer    <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_rx_drop  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      r_rx_drop  <= 1'b0;
      case (r_state)
        ST_WAIT_A: begin
          if (i_rx_done) begin
            r_alu_a <= i_rx_data;
            r_timer <= '0;
            r_state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_done) begin
            r_alu_b <= i_rx_data;
            r_timer <= '0;
            r_state <= ST_WAIT_OP;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_timer   <= '0;
            r_state   <= ST_WAIT_A;
          end else if (r_timer != TIMER_LAST) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_OP: begin
          // A byte arriving on the expiry cycle is still accepted.
          if (i_rx_done) begin
            r_alu_op <= i_rx_data[NB_OP-1:0];
            r_timer  <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_EXEC;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_timer   <= '0;
            r_state   <= ST_WAIT_A;
          end else if (r_timer != TIMER_LAST) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_EXEC: begin
          r_tx_data  <= i_alu_result;
          r_tx_start <= 1'b1;
          r_rx_drop  <= i_rx_done;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          r_rx_drop <= i_rx_done;
          r_state   <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          r_rx_drop <= i_rx_done;
          if (i_tx_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_WAIT_A;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_timer <= '0;
          r_state <= ST_WAIT_A;
        end
      endcase
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_busy;
  assign o_timeout  = r_timeout;
  assign o_rx_drop  = r_rx_drop;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Randomized bench for uart_alu_interface against a frame-level reference model.
module tb_uart_alu_interface;

  localparam int unsigned T = 10;

  logic       clk = 1'b0;
  logic       i_reset, i_rx_done, i_tx_done;
  logic [7:0] i_rx_data;
  logic [7:0] w_alu;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_timeout, o_rx_drop;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign w_alu = alu_f(o_alu_a, o_alu_b, o_alu_op);

  uart_alu_interface #(.NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(T)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_alu_result(w_alu), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy),
    .o_timeout(o_timeout), .o_rx_drop(o_rx_drop));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame progress as a byte count plus a post-frame phase
  // (0 collecting, 1 computing, 2 sending, 3 awaiting TX completion).
  int         m_got, m_phase, m_idle;
  logic [7:0] m_bytes [3];
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  bit         m_start, m_tout, m_drop, m_valid = 0;

  always @(posedge clk) begin
    m_start = 0; m_tout = 0; m_drop = 0;
    if (i_reset) begin
      m_valid = 1; m_got = 0; m_phase = 0; m_idle = 0;
      m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
    end else if (m_phase == 0) begin
      if (i_rx_done) begin
        m_bytes[m_got] = i_rx_data;
        m_idle = 0;
        if (m_got == 0) m_a = i_rx_data;
        if (m_got == 1) m_b = i_rx_data;
        if (m_got == 2) begin m_op = i_rx_data[5:0]; m_phase = 1; m_got = 0; end
        else m_got++;
      end else if (m_got > 0) begin
        m_idle++;
        if (m_idle == T) begin m_tout = 1; m_got = 0; m_idle = 0; end
      end
    end else begin
      m_drop = i_rx_done;
      if (m_phase == 1) begin
        m_tx = alu_f(m_bytes[0], m_bytes[1], m_bytes[2][5:0]);
        m_start = 1; m_phase = 2;
      end else if (m_phase == 2) m_phase = 3;
      else if (i_tx_done) m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("alu_a", 32'(o_alu_a), 32'(m_a));
      check("alu_b", 32'(o_alu_b), 32'(m_b));
      check("alu_op", 32'(o_alu_op), 32'(m_op));
      check("tx_data", 32'(o_tx_data), 32'(m_tx));
      check("tx_start", 32'(o_tx_start), 32'(m_start));
      check("busy", 32'(o_busy), 32'(m_phase != 0));
      check("timeout", 32'(o_timeout), 32'(m_tout));
      check("rx_drop", 32'(o_rx_drop), 32'(m_drop));
    end
  end

  task automatic cyc(input bit rst, input bit rx, input logic [7:0] d, input bit tx);
    i_reset = rst; i_rx_done = rx; i_rx_data = d; i_tx_done = tx;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 8'h00, 0);
  endtask

  initial begin
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);

    // Basic frame: 5 + 3
    cyc(0, 1, 8'h05, 0); cyc(0, 1, 8'h03, 0); cyc(0, 1, 8'h20, 0);
    check("basic_a", 32'(o_alu_a), 32'h05);
    check("basic_b", 32'(o_alu_b), 32'h03);
    check("basic_op", 32'(o_alu_op), 32'h20);
    check("basic_start_early", 32'(o_tx_start), 32'd0);
    idle(1);
    check("basic_start", 32'(o_tx_start), 32'd1);
    check("basic_tx", 32'(o_tx_data), 32'h08);
    idle(1);
    check("basic_start_once", 32'(o_tx_start), 32'd0);
    idle(3);
    check("basic_busy", 32'(o_busy), 32'd1);
    cyc(0, 0, 8'h00, 1);
    check("basic_idle", 32'(o_busy), 32'd0);

    // Wrapping sum
    cyc(0, 1, 8'hFF, 0); cyc(0, 1, 8'h01, 0); cyc(0, 1, 8'h20, 0); idle(1);
    check("wrap_tx", 32'(o_tx_data), 32'h00);
    idle(2); cyc(0, 0, 8'h00, 1);

    // Timeout after operand A only
    cyc(0, 1, 8'h07, 0);
    idle(T - 1);
    check("tout_early", 32'(o_timeout), 32'd0);
    idle(1);
    check("tout_pulse", 32'(o_timeout), 32'd1);
    check("tout_keep_a", 32'(o_alu_a), 32'h07);
    cyc(0, 1, 8'h09, 0); cyc(0, 1, 8'h04, 0); cyc(0, 1, 8'h22, 0); idle(1);
    check("after_tout_tx", 32'(o_tx_data), 32'h05);
    idle(1); cyc(0, 0, 8'h00, 1);

    // Opcode on the expiry cycle wins over the timeout
    cyc(0, 1, 8'h0C, 0); cyc(0, 1, 8'h0A, 0);
    idle(T - 1);
    cyc(0, 1, 8'h26, 0);
    check("tie_no_tout", 32'(o_timeout), 32'd0);
    check("tie_busy", 32'(o_busy), 32'd1);
    idle(1);
    check("tie_tx", 32'(o_tx_data), 32'h06);
    idle(1);

    // Byte dropped while waiting on TX
    cyc(0, 1, 8'hAA, 0);
    check("drop_pulse", 32'(o_rx_drop), 32'd1);
    check("drop_keep_a", 32'(o_alu_a), 32'h0C);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'h11, 0);
    check("drop_next_a", 32'(o_alu_a), 32'h11);

    // Reset in WAIT_OP, then in WAIT_TX
    cyc(0, 1, 8'h22, 0);
    cyc(1, 0, 8'h00, 0);
    check("rst_op_a", 32'(o_alu_a), 32'd0);
    cyc(0, 0, 8'h00, 1);
    check("rst_op_stray", 32'(o_busy), 32'd0);
    cyc(0, 1, 8'h01, 0); cyc(0, 1, 8'h02, 0); cyc(0, 1, 8'h20, 0); idle(3);
    cyc(1, 0, 8'h00, 0);
    check("rst_tx_busy", 32'(o_busy), 32'd0);
    check("rst_tx_data2", 32'(o_tx_data), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit rst, rx, tx;
      logic [7:0] d;
      logic [7:0] ops [7];
      ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h3F};
      if ($urandom % 60 == 0) idle(int'($urandom_range(T - 2, T + 2)));
      rst = ($urandom % 400 == 0);
      rx  = ($urandom % 4 == 0);
      tx  = (m_phase == 3) ? ($urandom % 3 == 0) : ($urandom % 40 == 0);
      d   = (m_got == 2 && $urandom % 4 != 0) ? ops[$urandom % 7] : 8'($urandom);
      cyc(rst, rx, d, tx);
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
